ads5404_bringup_ctrl: RTL and testbench

ADS5404_BRINGUP_CTRL -- requirements
Module: ads5404_bringup_ctrl

---
 rtl/ads5404_pkg.sv | 43 ++++
 rtl/ads5404_sync_ff.sv | 22 ++
 rtl/ads5404_bringup_ctrl.sv | 134 +++++++++++++
 tb/tb_ads5404_bringup_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads5404_pkg.sv
// Shared state codes, counter width and output decode for the ADS5404 bring-up controller.
package ads5404_pkg;
  localparam int unsigned CNT_W        = 24;
  localparam int unsigned DPRST_CYCLES = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HWRST     = 4'd1,
    ST_SETTLE    = 4'd2,
    ST_ENABLE    = 4'd3,
    ST_DPRST     = 4'd4,
    ST_WAIT_LOCK = 4'd5,
    ST_SYNC      = 4'd6,
    ST_READY     = 4'd7,
    ST_FAIL      = 4'd8
  } state_e;

  typedef struct packed {
    logic hw_nrst;
    logic adc_enable;
    logic dp_rst;
    logic adc_sync;
    logic ready;
    logic busy;
    logic fail;
  } outs_t;

  function automatic outs_t decode_outs(input state_e st);
    outs_t o;
    o.hw_nrst    = (st != ST_HWRST);
    o.adc_enable = (st inside {ST_ENABLE, ST_DPRST, ST_WAIT_LOCK, ST_SYNC, ST_READY});
    o.dp_rst     = (st inside {ST_IDLE, ST_HWRST, ST_SETTLE, ST_ENABLE, ST_DPRST, ST_FAIL});
    o.adc_sync   = (st == ST_SYNC);
    o.ready      = (st == ST_READY);
    o.busy       = !(st inside {ST_IDLE, ST_READY, ST_FAIL});
    o.fail       = (st == ST_FAIL);
    return o;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/ads5404_sync_ff.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module ads5404_sync_ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  (* async_reg = "true" *) logic meta_q;
  (* async_reg = "true" *) logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ads5404_bringup_ctrl.sv
// ADS5404 power-up sequencer: chip reset, settle, enable, datapath reset, PLL lock wait, sync pulse.
// state|meaning: IDLE parked | HWRST chip reset | SETTLE post-reset wait | ENABLE enable pin | DPRST datapath reset | WAIT_LOCK await PLL | SYNC sync pulse | READY streaming | FAIL retries exhausted
module ads5404_bringup_ctrl
  import ads5404_pkg::*;
#(
  parameter int unsigned HWRST_CYCLES  = 1000,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SYNC_CYCLES   = 16,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       resync_i,
  input  logic       pll_locked_i,
  output logic       hw_nrst_o,
  output logic       adc_enable_o,
  output logic       dp_rst_o,
  output logic       adc_sync_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       fail_o,
  output logic [3:0] state_o,
  output logic [1:0] retries_o
);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HWRST_LOAD  = CNT_W'(HWRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DPRST_LOAD  = CNT_W'(DPRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYNC_LOAD   = CNT_W'(SYNC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retries_q, retries_d;
  logic             start_q;
  outs_t            outs_q;
  logic             lock_s;
  logic             start_edge;
  logic             cnt_zero;
  logic             retry_ok;

  ads5404_sync_ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  assign start_edge = start_i & ~start_q;
  assign cnt_zero   = (cnt_q == '0);
  assign retry_ok   = ({30'd0, retries_q} < MAX_RETRIES);

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
    unique case (state_q)
      ST_IDLE, ST_FAIL: ;
      ST_HWRST: if (cnt_zero) begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: if (cnt_zero) state_d = ST_ENABLE;
      ST_ENABLE: begin
        state_d = ST_DPRST;
        cnt_d   = DPRST_LOAD;
      end
      ST_DPRST: if (cnt_zero) begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = LOCK_LOAD;
      end
      // Lock is checked before expiry so a simultaneous arrival still counts as success.
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LOAD;
        end else if (cnt_zero) begin
          if (retry_ok) begin
            state_d   = ST_DPRST;
            cnt_d     = DPRST_LOAD;
            retries_d = sat_inc2(retries_q);
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_SYNC: if (cnt_zero) state_d = ST_READY;
      ST_READY: begin
        if (!lock_s) begin
          state_d   = ST_DPRST;
          cnt_d     = DPRST_LOAD;
          retries_d = sat_inc2(retries_q);
        end else if (resync_i) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_edge && (state_q inside {ST_IDLE, ST_READY, ST_FAIL})) begin
      state_d   = ST_HWRST;
      cnt_d     = HWRST_LOAD;
      retries_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      retries_q <= '0;
      start_q   <= 1'b0;
      outs_q    <= decode_outs(ST_IDLE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      start_q   <= start_i;
      outs_q    <= decode_outs(state_d);
    end
  end

  assign hw_nrst_o    = outs_q.hw_nrst;
  assign adc_enable_o = outs_q.adc_enable;
  assign dp_rst_o     = outs_q.dp_rst;
  assign adc_sync_o   = outs_q.adc_sync;
  assign ready_o      = outs_q.ready;
  assign busy_o       = outs_q.busy;
  assign fail_o       = outs_q.fail;
  assign state_o      = state_q;
  assign retries_o    = retries_q;
endmodule

// File: tb/tb_ads5404_bringup_ctrl.sv
// Bench for the ADS5404 bring-up controller: per-cycle trace model of the sequence plus targeted scenarios.
module tb_ads5404_bringup_ctrl;
  localparam int HW   = 10;
  localparam int SE   = 20;
  localparam int LT   = 50;
  localparam int SY   = 4;
  localparam int MAXR = 3;
  localparam int DPL  = 8;

  logic       clk_i        = 1'b0;
  logic       rst_i        = 1'b1;
  logic       start_i      = 1'b0;
  logic       resync_i     = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       hw_nrst_o, adc_enable_o, dp_rst_o, adc_sync_o, ready_o, busy_o, fail_o;
  logic [3:0] state_o;
  logic [1:0] retries_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_st[$];
  int exp_rt[$];
  int lock_idx = -1;
  int exp_retries_now = 0;

  always #5 clk_i = ~clk_i;

  ads5404_bringup_ctrl #(
    .HWRST_CYCLES (HW),
    .SETTLE_CYCLES(SE),
    .LOCK_TIMEOUT (LT),
    .SYNC_CYCLES  (SY),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .resync_i     (resync_i),
    .pll_locked_i (pll_locked_i),
    .hw_nrst_o    (hw_nrst_o),
    .adc_enable_o (adc_enable_o),
    .dp_rst_o     (dp_rst_o),
    .adc_sync_o   (adc_sync_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .fail_o       (fail_o),
    .state_o      (state_o),
    .retries_o    (retries_o)
  );

  // {hw_nrst, adc_enable, dp_rst, adc_sync, ready, busy, fail} required in each state
  function automatic logic [6:0] spec_outs(input int st);
    case (st)
      0:       return 7'b1010000;
      1:       return 7'b0010010;
      2:       return 7'b1010010;
      3:       return 7'b1110010;
      4:       return 7'b1110010;
      5:       return 7'b1100010;
      6:       return 7'b1101010;
      7:       return 7'b1100100;
      8:       return 7'b1010001;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [6:0] dut_outs();
    return {hw_nrst_o, adc_enable_o, dp_rst_o, adc_sync_o, ready_o, busy_o, fail_o};
  endfunction

  task automatic push(input int s, input int r);
    exp_st.push_back(s);
    exp_rt.push_back(r);
  endtask

  // Expected state/retries per cycle after a start edge; nfail = number of lock timeouts before lock
  // arrives t cycles into WAIT_LOCK (nfail > MAXR means lock never arrives).
  task automatic build_model(input int nfail, input int t, input int tail);
    exp_st.delete();
    exp_rt.delete();
    lock_idx = -1;
    repeat (HW) push(1, 0);
    repeat (SE) push(2, 0);
    push(3, 0);
    for (int a = 0; a <= MAXR; a++) begin
      repeat (DPL) push(4, a);
      if (a == nfail) begin
        repeat (t) push(5, a);
        lock_idx = exp_st.size() - 1;
        repeat (SY) push(6, a);
        repeat (tail) push(7, a);
        return;
      end
      repeat (LT) push(5, a);
    end
    repeat (tail) push(8, MAXR);
  endtask

  task automatic run_bringup(input string tag, input int nfail, input int t,
                             input int rst_at, input int glitch_at);
    int ncyc;
    int hw_low_n    = 0;
    int hw_last_low = -1;
    int en_first    = -1;
    int sync_n      = 0;
    int dp_n        = 0;
    int prev_st     = -1;
    build_model(nfail, t, 6);
    ncyc = (rst_at >= 0) ? rst_at + 2 : exp_st.size();
    @(negedge clk_i);
    start_i      = 1'b1;
    pll_locked_i = 1'b0;
    resync_i     = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_i);
      if (rst_at >= 0 && c == rst_at + 1) begin
        n_cmp++;
        if ({state_o, retries_o, dut_outs()} !== {4'd0, 2'd0, spec_outs(0)}) begin
          n_bad++;
          $display("FAIL %s reset_abort: got st=%0d rt=%0d outs=%b, want st=0 rt=0 outs=%b",
                   tag, state_o, retries_o, dut_outs(), spec_outs(0));
        end
        rst_i = 1'b0;
        exp_retries_now = 0;
      end else begin
        n_cmp++;
        if (int'(state_o) !== exp_st[c]) begin
          n_bad++;
          $display("FAIL %s state@%0d: got %0d want %0d", tag, c, state_o, exp_st[c]);
        end
        n_cmp++;
        if (int'(retries_o) !== exp_rt[c]) begin
          n_bad++;
          $display("FAIL %s retries@%0d: got %0d want %0d", tag, c, retries_o, exp_rt[c]);
        end
        n_cmp++;
        if (dut_outs() !== spec_outs(exp_st[c])) begin
          n_bad++;
          $display("FAIL %s outs@%0d: got %b want %b", tag, c, dut_outs(), spec_outs(exp_st[c]));
        end
        if (!hw_nrst_o) begin
          hw_low_n++;
          hw_last_low = c;
        end
        if (adc_enable_o && en_first < 0) en_first = c;
        if (adc_sync_o) sync_n++;
        if (int'(state_o) == 4 && prev_st != 4) dp_n++;
        prev_st = int'(state_o);
      end
      if (c == 0) start_i = 1'b0;
      if (glitch_at >= 0 && c == glitch_at) start_i = 1'b1;
      if (glitch_at >= 0 && c == glitch_at + 1) start_i = 1'b0;
      if (c == lock_idx - 2) pll_locked_i = 1'b1;
      if (c == rst_at) rst_i = 1'b1;
    end
    if (rst_at < 0) begin
      exp_retries_now = exp_rt[exp_rt.size() - 1];
      n_cmp++;
      if (hw_low_n != HW) begin
        n_bad++;
        $display("FAIL %s hwrst_width: got %0d want %0d", tag, hw_low_n, HW);
      end
      n_cmp++;
      if (en_first - hw_last_low != SE + 1) begin
        n_bad++;
        $display("FAIL %s enable_delay: got %0d want %0d", tag, en_first - hw_last_low, SE + 1);
      end
      n_cmp++;
      if (sync_n != ((nfail <= MAXR) ? SY : 0)) begin
        n_bad++;
        $display("FAIL %s sync_width: got %0d want %0d", tag, sync_n, (nfail <= MAXR) ? SY : 0);
      end
      n_cmp++;
      if (dp_n != ((nfail < MAXR) ? nfail : MAXR) + 1) begin
        n_bad++;
        $display("FAIL %s dprst_passes: got %0d want %0d", tag, dp_n,
                 ((nfail < MAXR) ? nfail : MAXR) + 1);
      end
      n_cmp++;
      if (nfail <= MAXR ? (ready_o !== 1'b1) : (fail_o !== 1'b1 || adc_enable_o !== 1'b0)) begin
        n_bad++;
        $display("FAIL %s end_status: got ready=%b fail=%b en=%b want %s", tag, ready_o, fail_o,
                 adc_enable_o, (nfail <= MAXR) ? "ready" : "fail, enable low");
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      resync_i     = 1'($urandom_range(0, 1));
      pll_locked_i = 1'($urandom_range(0, 1));
      n_cmp++;
      if ({state_o, retries_o, dut_outs()} !== {4'd0, 2'd0, spec_outs(0)}) begin
        n_bad++;
        $display("FAIL reset_values: got st=%0d rt=%0d outs=%b want st=0 rt=0 outs=%b",
                 state_o, retries_o, dut_outs(), spec_outs(0));
      end
    end
    rst_i        = 1'b0;
    resync_i     = 1'b0;
    pll_locked_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      n_cmp++;
      if (state_o !== 4'd0 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_hold: got st=%0d busy=%b want st=0 busy=0", state_o, busy_o);
      end
    end
  endtask

  task automatic test_lock_drop();
    int first_low = -1;
    int st_at_low = -1;
    int rt_at_low = -1;
    int back      = -1;
    int want_rt;
    want_rt = (exp_retries_now < 3) ? exp_retries_now + 1 : 3;
    pll_locked_i = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_i);
      if (c == 1) pll_locked_i = 1'b1;
      if (first_low < 0 && !ready_o) begin
        first_low = c;
        st_at_low = int'(state_o);
        rt_at_low = int'(retries_o);
      end
      if (first_low >= 0 && back < 0 && ready_o) back = c;
    end
    n_cmp++;
    if (first_low != 3) begin
      n_bad++;
      $display("FAIL lock_drop ready_low_at: got %0d want 3", first_low);
    end
    n_cmp++;
    if (st_at_low != 4) begin
      n_bad++;
      $display("FAIL lock_drop state: got %0d want 4", st_at_low);
    end
    n_cmp++;
    if (rt_at_low != want_rt) begin
      n_bad++;
      $display("FAIL lock_drop retries: got %0d want %0d", rt_at_low, want_rt);
    end
    n_cmp++;
    if (back != 3 + DPL + 1 + SY) begin
      n_bad++;
      $display("FAIL lock_drop ready_back_at: got %0d want %0d", back, 3 + DPL + 1 + SY);
    end
    exp_retries_now = want_rt;
  endtask

  task automatic test_resync();
    int sync_n  = 0;
    int overlap = 0;
    int first   = -1;
    logic rdy_after = 1'b0;
    resync_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 1) resync_i = 1'b0;
      if (adc_sync_o) begin
        sync_n++;
        if (first < 0) first = c;
        if (ready_o) overlap++;
      end
      if (c == 1 + SY) rdy_after = ready_o;
    end
    n_cmp++;
    if (first != 1) begin
      n_bad++;
      $display("FAIL resync sync_start: got %0d want 1", first);
    end
    n_cmp++;
    if (sync_n != SY) begin
      n_bad++;
      $display("FAIL resync sync_width: got %0d want %0d", sync_n, SY);
    end
    n_cmp++;
    if (overlap != 0) begin
      n_bad++;
      $display("FAIL resync ready_during_sync: got %0d cycles want 0", overlap);
    end
    n_cmp++;
    if (rdy_after !== 1'b1) begin
      n_bad++;
      $display("FAIL resync ready_after: got %b want 1", rdy_after);
    end
  endtask

  task automatic test_random();
    int nf;
    int tt;
    for (int i = 0; i < 6; i++) begin
      nf = $urandom_range(0, MAXR + 1);
      tt = $urandom_range(1, LT);
      run_bringup($sformatf("random%0d_nf%0d_t%0d", i, nf, tt), nf, tt, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    run_bringup("basic", 0, 1, -1, -1);
    test_lock_drop();
    test_resync();
    run_bringup("timeout_fail", MAXR + 1, 1, -1, -1);
    run_bringup("lock_at_expiry", 0, LT, -1, -1);
    run_bringup("lock_at_expiry_retry2", 2, LT, -1, -1);
    run_bringup("reset_abort", 0, 1, 4, -1);
    run_bringup("start_ignored", 1, 7, -1, 15);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
